// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the integer ALU: resolves operands (x0, EX/WB forwarding, immediate),
// stalls on pending loads, and presents the bundle through a two-entry skid buffer.
module alu_operand_stage #(
    parameter int unsigned W    = 32,
    parameter int unsigned F3_W = 3,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [F3_W-1:0] in_func3,
    input  logic            in_mode_flag,
    input  logic [RA_W-1:0] in_rs1_idx,
    input  logic [RA_W-1:0] in_rs2_idx,
    input  logic [W-1:0]    in_rs1_data,
    input  logic [W-1:0]    in_rs2_data,
    input  logic            in_use_imm,
    input  logic [W-1:0]    in_imm,
    input  logic [RA_W-1:0] in_rd_idx,
    input  logic            ex_fwd_valid,
    input  logic [RA_W-1:0] ex_fwd_idx,
    input  logic [W-1:0]    ex_fwd_data,
    input  logic            wb_valid,
    input  logic [RA_W-1:0] wb_idx,
    input  logic [W-1:0]    wb_data,
    input  logic            busy_valid,
    input  logic [RA_W-1:0] busy_idx,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [F3_W-1:0] out_func3,
    output logic            out_mode_flag,
    output logic [W-1:0]    out_rs1,
    output logic [W-1:0]    out_rs2,
    output logic [RA_W-1:0] out_rd_idx
);

    typedef struct packed {
        logic [F3_W-1:0] func3;
        logic            mode_flag;
        logic [W-1:0]    rs1;
        logic [W-1:0]    rs2;
        logic [RA_W-1:0] rd_idx;
    } entry_t;

    entry_t out_q, out_d, skid_q, skid_d, new_entry;
    logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic   stall, accept, out_free;

    // EX has priority over WB; x0 always reads zero, so a forward to index 0 never matches.
    function automatic logic [W-1:0] resolve(
        input logic [RA_W-1:0] idx,
        input logic [W-1:0]    rf_data,
        input logic            ex_v,
        input logic [RA_W-1:0] ex_i,
        input logic [W-1:0]    ex_d,
        input logic            wb_v,
        input logic [RA_W-1:0] wb_i,
        input logic [W-1:0]    wb_d
    );
        if (idx == '0)                    return '0;
        else if (ex_v && (ex_i == idx))   return ex_d;
        else if (wb_v && (wb_i == idx))   return wb_d;
        else                              return rf_data;
    endfunction

    always_comb begin
        new_entry.func3     = in_func3;
        new_entry.mode_flag = in_mode_flag;
        new_entry.rs1       = resolve(in_rs1_idx, in_rs1_data, ex_fwd_valid, ex_fwd_idx,
                                      ex_fwd_data, wb_valid, wb_idx, wb_data);
        new_entry.rs2       = in_use_imm ? in_imm
                            : resolve(in_rs2_idx, in_rs2_data, ex_fwd_valid, ex_fwd_idx,
                                      ex_fwd_data, wb_valid, wb_idx, wb_data);
        new_entry.rd_idx    = in_rd_idx;
    end

    assign stall = busy_valid && (busy_idx != '0) &&
                   ((busy_idx == in_rs1_idx) || (!in_use_imm && (busy_idx == in_rs2_idx)));
    // Registered skid occupancy only, so in_ready never looks at out_ready.
    assign in_ready = !skid_valid_q && !stall;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = new_entry;
            end else if (accept) begin
                out_d       = new_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_func3     = out_q.func3;
    assign out_mode_flag = out_q.mode_flag;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_rd_idx    = out_q.rd_idx;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: FIFO-occupancy model checked every cycle, plus directed
// scenarios with literal expectations and a randomized valid/ready phase.
module tb_alu_operand_stage;

    localparam int unsigned W = 32, F3_W = 3, RA_W = 5;

    logic            clk = 1'b0, rstn = 1'b0;
    logic            in_valid = 0, in_ready;
    logic [F3_W-1:0] in_func3 = '0;
    logic            in_mode_flag = 0;
    logic [RA_W-1:0] in_rs1_idx = '0, in_rs2_idx = '0, in_rd_idx = '0;
    logic [W-1:0]    in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
    logic            in_use_imm = 0;
    logic            ex_fwd_valid = 0, wb_valid = 0, busy_valid = 0;
    logic [RA_W-1:0] ex_fwd_idx = '0, wb_idx = '0, busy_idx = '0;
    logic [W-1:0]    ex_fwd_data = '0, wb_data = '0;
    logic            out_valid, out_ready = 0, out_mode_flag;
    logic [F3_W-1:0] out_func3;
    logic [W-1:0]    out_rs1, out_rs2;
    logic [RA_W-1:0] out_rd_idx;

    alu_operand_stage #(.W(W), .F3_W(F3_W), .RA_W(RA_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_func3(in_func3), .in_mode_flag(in_mode_flag), .in_rs1_idx(in_rs1_idx),
        .in_rs2_idx(in_rs2_idx), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .in_rd_idx(in_rd_idx),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_idx(ex_fwd_idx), .ex_fwd_data(ex_fwd_data),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .busy_valid(busy_valid), .busy_idx(busy_idx), .out_valid(out_valid),
        .out_ready(out_ready), .out_func3(out_func3), .out_mode_flag(out_mode_flag),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd_idx(out_rd_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [F3_W-1:0] func3;
        logic            mode;
        logic [W-1:0]    rs1, rs2;
        logic [RA_W-1:0] rd;
    } op_t;

    op_t held[$];   // entries the stage currently holds, oldest first
    int  n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] operand(input logic [RA_W-1:0] idx, input logic [W-1:0] rf);
        if (idx == 0) return 0;
        if (ex_fwd_valid && ex_fwd_idx == idx) return ex_fwd_data;
        if (wb_valid && wb_idx == idx) return wb_data;
        return rf;
    endfunction

    function automatic bit exp_stall();
        if (!busy_valid || busy_idx == 0) return 0;
        return (busy_idx == in_rs1_idx) || (!in_use_imm && busy_idx == in_rs2_idx);
    endfunction

    // Compare on the falling edge; the model then absorbs what the next rising edge will do.
    always @(negedge clk) begin
        bit exp_ready;
        if (!rstn) begin
            held.delete();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", {out_func3, out_mode_flag, out_rs1, out_rs2, out_rd_idx}, 0);
            chk("rst_in_ready", in_ready, !exp_stall());
        end else begin
            exp_ready = (held.size() < 2) && !exp_stall();
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, held.size() > 0);
            if (held.size() > 0) begin
                chk("out_func3", out_func3, held[0].func3);
                chk("out_mode", out_mode_flag, held[0].mode);
                chk("out_rs1", out_rs1, held[0].rs1);
                chk("out_rs2", out_rs2, held[0].rs2);
                chk("out_rd", out_rd_idx, held[0].rd);
            end
            if (held.size() > 0 && out_ready) void'(held.pop_front());
            if (in_valid && exp_ready) begin
                op_t e;
                e.func3 = in_func3;
                e.mode  = in_mode_flag;
                e.rs1   = operand(in_rs1_idx, in_rs1_data);
                e.rs2   = in_use_imm ? in_imm : operand(in_rs2_idx, in_rs2_data);
                e.rd    = in_rd_idx;
                held.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [RA_W-1:0] r1, input logic [W-1:0] d1,
                          input logic [RA_W-1:0] r2, input logic [W-1:0] d2,
                          input logic imm_sel, input logic [W-1:0] imm);
        in_rs1_idx = r1; in_rs1_data = d1; in_rs2_idx = r2; in_rs2_data = d2;
        in_use_imm = imm_sel; in_imm = imm;
        in_func3 = r1[2:0]; in_mode_flag = r2[0]; in_rd_idx = r1 + r2;
    endtask

    // One-cycle issue with out_ready high, then check the registered operands.
    task automatic issue_chk(input string name, input logic [W-1:0] e1, input logic [W-1:0] e2);
        in_valid = 1; step(); in_valid = 0;
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_rs1"}, out_rs1, e1);
        chk({name, "_rs2"}, out_rs2, e2);
        step();
    endtask

    initial begin
        step(); step();
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        step();
        rstn = 1;
        out_ready = 1;

        // Regfile read plus immediate
        set_op(3, 5, 9, 99, 1, 7);
        issue_chk("basic", 5, 7);
        chk("basic_func3", out_func3, 3'd3);

        // EX beats WB; x0 ignores forwarding; WB-only forward on rs2
        set_op(4, 'h11, 0, 0, 1, 0);
        ex_fwd_valid = 1; ex_fwd_idx = 4; ex_fwd_data = 'hAA;
        wb_valid = 1; wb_idx = 4; wb_data = 'hBB;
        issue_chk("ex_over_wb", 'hAA, 0);
        set_op(0, 'h55, 0, 0, 1, 3);
        ex_fwd_idx = 0; ex_fwd_data = 1; wb_idx = 0;
        issue_chk("x0", 0, 3);
        set_op(2, 'h22, 7, 'h77, 0, 'h9);
        ex_fwd_idx = 8; wb_idx = 7; wb_data = 'hCC;
        issue_chk("wb_rs2", 'h22, 'hCC);
        ex_fwd_valid = 0; wb_valid = 0;

        // Pending load on rs2 stalls only when rs2 is actually used
        busy_valid = 1; busy_idx = 6;
        set_op(1, 'h10, 6, 'h60, 0, 'h5);
        in_valid = 1;
        @(negedge clk); chk("busy_in_ready", in_ready, 0);
        step(); step();
        @(negedge clk); chk("busy_no_accept", out_valid, 0);
        in_use_imm = 1;
        @(negedge clk); chk("busy_imm_ready", in_ready, 1);
        step(); in_valid = 0;
        @(negedge clk); chk("busy_imm_rs2", out_rs2, 'h5);
        busy_valid = 0;
        step();

        // Back-pressure: A on out, B in skid, C refused, then drain in order
        out_ready = 0;
        set_op(1, 'hA, 0, 0, 1, 0); in_valid = 1; step();
        set_op(1, 'hB, 0, 0, 1, 0); step();
        set_op(1, 'hC, 0, 0, 1, 0);
        @(negedge clk);
        chk("skid_full_ready", in_ready, 0);
        chk("skid_hold_A", out_rs1, 'hA);
        step();
        @(negedge clk); chk("skid_still_A", out_rs1, 'hA);
        out_ready = 1; step();
        @(negedge clk); chk("drain_B", out_rs1, 'hB);
        step(); in_valid = 0;
        @(negedge clk); chk("drain_C", out_rs1, 'hC);
        step(); step();

        // Random valid/ready, forwarding and load-busy traffic
        for (int i = 0; i < 3000; i++) begin
            set_op(RA_W'($urandom_range(0, 7)), $urandom, RA_W'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 1)), $urandom);
            in_valid     = 1'($urandom_range(0, 3) != 0);
            out_ready    = 1'($urandom_range(0, 2) != 0);
            ex_fwd_valid = 1'($urandom_range(0, 1));
            ex_fwd_idx   = RA_W'($urandom_range(0, 7));
            ex_fwd_data  = $urandom;
            wb_valid     = 1'($urandom_range(0, 1));
            wb_idx       = RA_W'($urandom_range(0, 7));
            wb_data      = $urandom;
            busy_valid   = 1'($urandom_range(0, 3) == 0);
            busy_idx     = RA_W'($urandom_range(0, 7));
            step();
        end
        in_valid = 0; out_ready = 1; busy_valid = 0; ex_fwd_valid = 0; wb_valid = 0;
        step(); step(); step();

        // Reset with both entries occupied
        out_ready = 0;
        set_op(1, 'hD1, 0, 0, 1, 0); in_valid = 1; step();
        set_op(1, 'hD2, 0, 0, 1, 0); step(); in_valid = 0;
        #1 rstn = 0;
        #1 chk("async_rst_valid", out_valid, 0);
        chk("async_rst_rs1", out_rs1, 0);
        step(); step();
        rstn = 1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_valid", out_valid, 0);
        out_ready = 1;
        set_op(5, 'hE5, 0, 0, 1, 'h1);
        issue_chk("post_rst", 'hE5, 'h1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
